hazard_stall_ctrl: RTL

//  Stall/flush controller for the five-stage pipeline. Consumes the T_use_rs/T_use_rt codes held in the IF/D stage

---
 rtl/hazard_pkg.sv | 62 ++++++
 rtl/hazard_stall_ctrl_md_busy_tracker.sv | 48 ++++
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: T_use/T_new codes,
// mult/div opcodes, default busy-window lengths and the E/M shadow record.
package hazard_pkg;

    localparam int REG_AW   = 5;
    localparam int MD_CNT_W = 4;

    localparam logic [4:0] TUSE_0      = 5'd0;
    localparam logic [4:0] TUSE_1      = 5'd1;
    localparam logic [4:0] TUSE_2      = 5'd2;
    localparam logic [4:0] TUSE_NOREAD = 5'd31;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic [1:0] {
        MD_OP_NONE = 2'b00,
        MD_OP_MULT = 2'b01,
        MD_OP_DIV  = 2'b10
    } md_op_e;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [1:0]        tnew;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '{dst: '0, tnew: TNEW_0};

    // T_new counts down by one per stage and stays at zero once the value exists.
    function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
        return (tnew == TNEW_0) ? TNEW_0 : tnew - 2'd1;
    endfunction

    function automatic md_op_e md_op_decode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MD_OP_MULT;
            2'b10:   return MD_OP_DIV;
            default: return MD_OP_NONE;
        endcase
    endfunction

    function automatic logic operand_hazard(
        input logic [REG_AW-1:0] addr,
        input logic [4:0]        tuse,
        input logic [4:0]        tuse_none,
        input shadow_t           e,
        input shadow_t           m
    );
        logic used;
        logic e_hit;
        logic m_hit;
        used  = (addr != '0) && (tuse != tuse_none);
        e_hit = (addr == e.dst) && (tuse < {3'b000, e.tnew});
        m_hit = (addr == m.dst) && (tuse < {3'b000, m.tnew});
        return used && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// Tracks the E-stage busy window of the multiply/divide unit: loads a cycle
// count when a mult/div enters E, then counts down to zero.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  md_op_e e_md_op_i,
    output logic   md_start_o,
    output logic   md_busy_o
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
    localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;

    // A fresh issue reloads the window even if a previous one is still running.
    always_comb begin
        md_start_o = (e_md_op_i != MD_OP_NONE);
        md_cnt_d   = md_cnt_q;
        case (e_md_op_i)
            MD_OP_MULT: md_cnt_d = MULT_LOAD;
            MD_OP_DIV:  md_cnt_d = DIV_LOAD;
            default: begin
                if (md_cnt_q != '0) begin
                    md_cnt_d = md_cnt_q - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline: D-stage RAW checks
// against E/M shadows plus the mult/div busy window. Optional counters: HAZ_PERF_CNT_EN.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int         MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int         DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter logic [4:0] TUSE_NONE   = TUSE_NOREAD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [4:0]  d_tuse_rs,
    input  logic [4:0]  d_tuse_rt,
    input  logic [4:0]  d_dst,
    input  logic [1:0]  d_tnew,
    input  logic [1:0]  d_md_op,
    input  logic        d_hilo_use,
    output logic        stall,
    output logic        pc_en,
    output logic        ifd_en,
    output logic        de_flush,
    output logic        md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] stall_events
`endif
);

    shadow_t e_q;
    shadow_t e_d;
    shadow_t m_q;
    shadow_t m_d;
    md_op_e  e_md_q;
    md_op_e  e_md_d;

    logic haz_rs;
    logic haz_rt;
    logic haz_md;
    logic e_md_start;

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk        (clk),
        .reset      (reset),
        .e_md_op_i  (e_md_q),
        .md_start_o (e_md_start),
        .md_busy_o  (md_busy)
    );

    // W never stalls since its T_new is always zero, so only E and M are compared.
    always_comb begin
        haz_rs   = operand_hazard(d_rs, d_tuse_rs, TUSE_NONE, e_q, m_q);
        haz_rt   = operand_hazard(d_rt, d_tuse_rt, TUSE_NONE, e_q, m_q);
        haz_md   = d_hilo_use && (md_busy || e_md_start);
        stall    = haz_rs || haz_rt || haz_md;
        pc_en    = !stall;
        ifd_en   = !stall;
        de_flush = stall;
    end

    // A stalled D instruction enters E as a bubble, including its mult/div issue.
    always_comb begin
        e_d    = '{dst: d_dst, tnew: d_tnew};
        e_md_d = md_op_decode(d_md_op);
        if (stall) begin
            e_d    = SHADOW_BUBBLE;
            e_md_d = MD_OP_NONE;
        end
        m_d = '{dst: e_q.dst, tnew: tnew_age(e_q.tnew)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q    <= SHADOW_BUBBLE;
            m_q    <= SHADOW_BUBBLE;
            e_md_q <= MD_OP_NONE;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            e_md_q <= e_md_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic        stall_prev_q;
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_events_q;

    // Events count rising edges of stall; both counters wrap freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_prev_q   <= 1'b0;
            stall_cycles_q <= '0;
            stall_events_q <= '0;
        end else begin
            stall_prev_q <= stall;
            if (stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (stall && !stall_prev_q) begin
                stall_events_q <= stall_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign stall_events = stall_events_q;
`endif

endmodule
